inst_queue: RTL

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular buffer that takes masked
// fetch groups (compacted in lane order) and offers up to ISSUE_W oldest entries.
module inst_queue #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned FETCH_W = 2,
   parameter int unsigned ISSUE_W = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           fetch_valid,
   input  logic [FETCH_W-1:0]             fetch_mask,
   input  logic [32*FETCH_W-1:0]          fetch_inst,
   input  logic [31:0]                    fetch_pc,
   output logic                           fetch_ready,
   output logic [ISSUE_W-1:0]             issue_valid,
   output logic [32*ISSUE_W-1:0]          issue_inst,
   output logic [32*ISSUE_W-1:0]          issue_pc,
   input  logic [$clog2(ISSUE_W+1)-1:0]   issue_take,
   output logic [$clog2(DEPTH):0]         count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]    inst_mem_q [DEPTH];
   logic [31:0]    pc_mem_q   [DEPTH];
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   logic                accept;
   logic [FETCH_W-1:0]  wr_en;
   logic [AW-1:0]       wr_idx [FETCH_W];
   logic [31:0]         wr_pc  [FETCH_W];
   logic [CW-1:0]       n_enq, n_deq, n_valid, take_ext;

   assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_W);
   assign accept      = fetch_valid && fetch_ready && !flush;
   assign count       = count_q;

   // Compact masked lanes: each enabled lane takes the next free slot after the write pointer.
   always_comb begin
      logic [CW-1:0] off;
      off = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         wr_en[i]  = accept && fetch_mask[i];
         wr_idx[i] = wr_ptr_q + off[AW-1:0];
         wr_pc[i]  = fetch_pc + 32'(4 * i);
         if (wr_en[i]) off = off + CW'(1);
      end
      n_enq = off;
   end

   always_comb begin
      logic [AW-1:0] rd_idx;
      for (int i = 0; i < ISSUE_W; i++) begin
         rd_idx                = rd_ptr_q + AW'(i);
         issue_valid[i]        = 32'(count_q) > i;
         issue_inst[32*i +: 32] = issue_valid[i] ? inst_mem_q[rd_idx] : '0;
         issue_pc[32*i +: 32]   = issue_valid[i] ? pc_mem_q[rd_idx]   : '0;
      end
   end

   // Clamp the decode request to the lanes actually presented.
   always_comb begin
      n_valid  = (32'(count_q) >= ISSUE_W) ? CW'(ISSUE_W) : count_q;
      take_ext = CW'(issue_take);
      n_deq    = (take_ext < n_valid) ? take_ext : n_valid;
   end

   always_comb begin
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         count_d  = count_q + n_enq - n_deq;
         rd_ptr_d = rd_ptr_q + n_deq[AW-1:0];
         wr_ptr_d = wr_ptr_q + n_enq[AW-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Storage is left uninitialised; occupancy gates everything visible.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_W; i++) begin
         if (wr_en[i]) begin
            inst_mem_q[wr_idx[i]] <= fetch_inst[32*i +: 32];
            pc_mem_q[wr_idx[i]]   <= wr_pc[i];
         end
      end
   end

endmodule
